year_traveler: RTL and testbench



---
 rtl/year_traveler_pkg.sv | 20 ++
 rtl/year_step_unit.sv | 32 +++
 rtl/year_traveler.sv | 104 ++++++++++
 tb/tb_year_traveler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/year_traveler_pkg.sv
// year_traveler shared types and constants.
// Width, home year, FSM state and direction codes.
package year_traveler_pkg;

  localparam int K = 12;

  localparam logic signed [K-1:0] HOME_YEAR = K'(2019);
  localparam logic [K-1:0] ONE = K'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    ARRIVE = 2'd2
  } state_t;

  localparam logic [2:0] DIR_FWD  = 3'b100;
  localparam logic [2:0] DIR_STAY = 3'b010;
  localparam logic [2:0] DIR_BACK = 3'b001;

endpackage

// File: rtl/year_step_unit.sv
// Signed current-year up/down counter.
// Also forms year + delta one bit wider and flags overflow.
module year_step_unit
  import year_traveler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic signed [K-1:0] delta,
  output logic signed [K-1:0] year,
  output logic signed [K-1:0] sum,
  output logic                in_range
);

  logic signed [K:0] wide;

  assign wide = {year[K-1], year}
              + {delta[K-1], delta};
  assign sum = wide[K-1:0];
  // top two bits agree iff the sum fits in K bits
  assign in_range = (wide[K] == wide[K-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year <= HOME_YEAR;
    end else if (en) begin
      year <= up ? year + ONE : year - ONE;
    end
  end

endmodule

// File: rtl/year_traveler.sv
// Walks the current year toward year + delta, one year per clock.
// Reports arrival, abort and out-of-range requests as pulses.
module year_traveler
  import year_traveler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                delta_valid,
  input  logic signed [K-1:0] delta,
  output logic                delta_ready,
  input  logic                abort,
  output logic signed [K-1:0] year,
  output logic signed [K-1:0] target,
  output logic [K-1:0]        remaining,
  output logic                moving,
  output logic [2:0]          dir,
  output logic                arrived,
  output logic                aborted,
  output logic                err
);

  state_t state;

  logic signed [K-1:0] sum;
  logic                in_range;
  logic                step_en;
  logic [K-1:0]        mag;

  assign delta_ready = (state == IDLE);
  assign step_en = (state == TRAVEL) && !abort;
  // -2^(K-1) negates to itself, which reads as 2^(K-1) unsigned
  assign mag = delta[K-1] ? -delta : delta;

  year_step_unit u_step (
    .clk      (clk),
    .rst      (rst),
    .en       (step_en),
    .up       (dir == DIR_FWD),
    .delta    (delta),
    .year     (year),
    .sum      (sum),
    .in_range (in_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= HOME_YEAR;
      remaining <= '0;
      moving    <= 1'b0;
      dir       <= DIR_STAY;
      arrived   <= 1'b0;
      aborted   <= 1'b0;
      err       <= 1'b0;
    end else begin
      arrived <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (delta_valid) begin
            if (!in_range) begin
              err <= 1'b1;
            end else if (delta == '0) begin
              arrived <= 1'b1;
              dir     <= DIR_STAY;
            end else begin
              target    <= sum;
              remaining <= mag;
              dir       <= delta[K-1] ? DIR_BACK : DIR_FWD;
              moving    <= 1'b1;
              state     <= TRAVEL;
            end
          end
        end
        TRAVEL: begin
          if (abort) begin
            target    <= year;
            remaining <= '0;
            moving    <= 1'b0;
            dir       <= DIR_STAY;
            aborted   <= 1'b1;
            state     <= IDLE;
          end else begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              moving  <= 1'b0;
              arrived <= 1'b1;
              dir     <= DIR_STAY;
              state   <= ARRIVE;
            end
          end
        end
        ARRIVE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_year_traveler.sv
// Directed bench for year_traveler.
// Pulses are checked by a scoreboard monitor; levels inline.
module tb_year_traveler;

  logic               clk = 1'b0;
  logic               rst;
  logic               delta_valid;
  logic signed [11:0] delta;
  logic               delta_ready;
  logic               abort;
  logic signed [11:0] year;
  logic signed [11:0] target;
  logic [11:0]        remaining;
  logic               moving;
  logic [2:0]         dir;
  logic               arrived;
  logic               aborted;
  logic               err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] kind;
    int         yr;
    int         tg;
  } ev_t;

  localparam logic [2:0] EV_ARR = 3'b100;
  localparam logic [2:0] EV_ABT = 3'b010;
  localparam logic [2:0] EV_ERR = 3'b001;

  ev_t exp_q[$];

  year_traveler dut (
    .clk         (clk),
    .rst         (rst),
    .delta_valid (delta_valid),
    .delta       (delta),
    .delta_ready (delta_ready),
    .abort       (abort),
    .year        (year),
    .target      (target),
    .remaining   (remaining),
    .moving      (moving),
    .dir         (dir),
    .arrived     (arrived),
    .aborted     (aborted),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (arrived || aborted || err)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got %b, expected none",
                 {arrived, aborted, err});
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", int'({arrived, aborted, err}),
            int'(e.kind));
        chk("pulse_year", int'(year), e.yr);
        chk("pulse_target", int'(target), e.tg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int d);
    delta_valid = 1'b1;
    delta = 12'(d);
    tick();
    delta_valid = 1'b0;
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #2;
    chk({tag, "_year"}, int'(year), 2019);
    chk({tag, "_target"}, int'(target), 2019);
    chk({tag, "_ready"}, int'(delta_ready), 1);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_dir"}, int'(dir), 3'b010);
    chk({tag, "_rem"}, int'(remaining), 0);
    chk({tag, "_pulses"},
        int'({arrived, aborted, err}), 0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    delta_valid = 1'b0;
    delta = '0;
    abort = 1'b0;
    #1;
    do_reset("rst0");

    // forward +5
    exp_q.push_back('{EV_ARR, 2024, 2024});
    send(5);
    chk("fwd_moving", int'(moving), 1);
    chk("fwd_dir", int'(dir), 3'b100);
    chk("fwd_target", int'(target), 2024);
    chk("fwd_year0", int'(year), 2019);
    chk("fwd_rem0", int'(remaining), 5);
    chk("fwd_ready0", int'(delta_ready), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("fwd_year", int'(year), 2019 + i);
      chk("fwd_rem", int'(remaining), 5 - i);
    end
    chk("fwd_arr_ready", int'(delta_ready), 0);
    chk("fwd_arr_dir", int'(dir), 3'b010);
    chk("fwd_arr_moving", int'(moving), 0);
    tick();
    chk("fwd_idle_ready", int'(delta_ready), 1);

    // backward -3 from home
    do_reset("rst1");
    exp_q.push_back('{EV_ARR, 2016, 2016});
    send(-3);
    chk("bwd_dir", int'(dir), 3'b001);
    chk("bwd_target", int'(target), 2016);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bwd_year", int'(year), 2019 - i);
      chk("bwd_rem", int'(remaining), 3 - i);
    end
    tick();

    // zero request
    exp_q.push_back('{EV_ARR, 2016, 2016});
    send(0);
    chk("zero_moving", int'(moving), 0);
    chk("zero_year", int'(year), 2016);
    chk("zero_dir", int'(dir), 3'b010);
    tick();

    // out of range
    do_reset("rst2");
    exp_q.push_back('{EV_ERR, 2019, 2019});
    send(100);
    chk("err_ready", int'(delta_ready), 1);
    chk("err_year", int'(year), 2019);
    chk("err_moving", int'(moving), 0);
    tick();

    // most negative delta, then abort at once
    send(-2048);
    chk("min_target", int'(target), -29);
    chk("min_rem", int'(remaining), 2048);
    chk("min_dir", int'(dir), 3'b001);
    exp_q.push_back('{EV_ABT, 2019, 2019});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("min_abt_year", int'(year), 2019);
    chk("min_abt_rem", int'(remaining), 0);
    chk("min_abt_ready", int'(delta_ready), 1);
    tick();

    // +10, abort on third travel edge
    exp_q.push_back('{EV_ABT, 2021, 2021});
    send(10);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_year", int'(year), 2021);
    chk("abt_target", int'(target), 2021);
    chk("abt_ready", int'(delta_ready), 1);
    chk("abt_moving", int'(moving), 0);
    chk("abt_dir", int'(dir), 3'b010);
    tick();

    // reset mid travel
    do_reset("rst3");
    send(10);
    tick();
    tick();
    chk("mid_year", int'(year), 2021);
    do_reset("rst_mid");

    // abort on the would-be last step
    exp_q.push_back('{EV_ABT, 2020, 2020});
    send(2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("last_abt_year", int'(year), 2020);
    tick();

    // abort with request in idle is ignored
    exp_q.push_back('{EV_ARR, 2021, 2021});
    abort = 1'b1;
    send(1);
    abort = 1'b0;
    chk("idle_abt_moving", int'(moving), 1);
    tick();
    chk("idle_abt_year", int'(year), 2021);
    tick();
    tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
